// File: rtl/textlcd_pkg.sv
// Shared constants, FSM state type and character helpers for the textlcd_2 LCD driver.
package textlcd_pkg;

  localparam logic [7:0] CmdFunc   = 8'h38;
  localparam logic [7:0] CmdDisp   = 8'h0C;
  localparam logic [7:0] CmdEntry  = 8'h06;
  localparam logic [7:0] CmdClear  = 8'h01;
  localparam logic [7:0] CmdL1Addr = 8'h80;
  localparam logic [7:0] CmdL2Addr = 8'hC0;
  localparam logic [7:0] ChrSpace  = 8'h20;

  typedef enum logic [3:0] {
    StPwrup,
    StFunc,
    StDisp,
    StEntry,
    StClear,
    StL1Addr,
    StL1Chr,
    StL2Addr,
    StL2Chr
  } lcd_st_e;

  localparam int unsigned NumModes = 4;
  localparam logic [NumModes-1:0][31:0] ModeKey  = {32'd5, 32'd2, 32'd1, 32'd0};
  localparam logic [NumModes-1:0][31:0] ModeName = {"SET ", "STOP", "RUN ", "IDLE"};

  // Whole-word match: anything not in the table shows as "????".
  function automatic logic [31:0] mode_name(input logic [31:0] st);
    logic [31:0] name;
    name = "????";
    for (int i = 0; i < NumModes; i++) begin
      if (st == ModeKey[i]) name = ModeName[i];
    end
    return name;
  endfunction

  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
  endfunction

endpackage

// File: rtl/textlcd_char_gen.sv
// Combinational character generator: line 1 "MODE <name>", line 2 "ST=0x<hex>".
module textlcd_char_gen
  import textlcd_pkg::*;
(
  input  logic [31:0] state_i,
  input  logic        line_i,
  input  logic [3:0]  col_i,
  output logic [7:0]  char_o
);

  logic [31:0] name;
  assign name = mode_name(state_i);

  always_comb begin
    char_o = ChrSpace;
    case (col_i)
      4'd0:    char_o = line_i ? "S" : "M";
      4'd1:    char_o = line_i ? "T" : "O";
      4'd2:    char_o = line_i ? "=" : "D";
      4'd3:    char_o = line_i ? "0" : "E";
      4'd4:    char_o = line_i ? "x" : ChrSpace;
      4'd5:    char_o = line_i ? nib2ascii(state_i[31:28]) : name[31:24];
      4'd6:    char_o = line_i ? nib2ascii(state_i[27:24]) : name[23:16];
      4'd7:    char_o = line_i ? nib2ascii(state_i[23:20]) : name[15:8];
      4'd8:    char_o = line_i ? nib2ascii(state_i[19:16]) : name[7:0];
      4'd9:    char_o = line_i ? nib2ascii(state_i[15:12]) : ChrSpace;
      4'd10:   char_o = line_i ? nib2ascii(state_i[11:8])  : ChrSpace;
      4'd11:   char_o = line_i ? nib2ascii(state_i[7:4])   : ChrSpace;
      4'd12:   char_o = line_i ? nib2ascii(state_i[3:0])   : ChrSpace;
      default: char_o = ChrSpace;
    endcase
  end

endmodule

// File: rtl/textlcd_2.sv
// HD44780 2x16 write-only driver: timed init sequence, then continuous two-line refresh
// showing a mode name and the hex value of a software state word.
module textlcd_2
  import textlcd_pkg::*;
#(
  parameter int unsigned TICK_CYCLES   = 25000,
  parameter int unsigned POWERUP_TICKS = 20,
  parameter int unsigned CLEAR_TICKS   = 2,
  parameter int unsigned EN_SETUP      = 2,
  parameter int unsigned EN_WIDTH      = 12
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] state,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic [7:0]  lcd_data
);

  localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  lcd_st_e         fsm_q, fsm_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      sub_q, sub_d;
  logic [31:0]     snap_q, snap_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            strobe_q, strobe_d;
  logic            step_end;
  logic [7:0]      chr;

  assign step_end = (cnt_q == CntW'(TICK_CYCLES - 1));
  assign cnt_d    = step_end ? '0 : cnt_q + 1'b1;

  // Characters come only from the per-frame snapshot so a frame never tears.
  textlcd_char_gen u_char_gen (
    .state_i (snap_q),
    .line_i  (fsm_d == StL2Chr),
    .col_i   (sub_d[3:0]),
    .char_o  (chr)
  );

  always_comb begin
    fsm_d    = fsm_q;
    sub_d    = sub_q;
    snap_d   = snap_q;
    rs_d     = rs_q;
    data_d   = data_q;
    strobe_d = strobe_q;
    if (step_end) begin
      sub_d = '0;
      unique case (fsm_q)
        StPwrup:  if (sub_q == 8'(POWERUP_TICKS - 1)) fsm_d = StFunc; else sub_d = sub_q + 8'd1;
        StFunc:   fsm_d = StDisp;
        StDisp:   fsm_d = StEntry;
        StEntry:  fsm_d = StClear;
        StClear:  if (sub_q == 8'(CLEAR_TICKS - 1)) fsm_d = StL1Addr; else sub_d = sub_q + 8'd1;
        StL1Addr: fsm_d = StL1Chr;
        StL1Chr:  if (sub_q == 8'd15) fsm_d = StL2Addr; else sub_d = sub_q + 8'd1;
        StL2Addr: fsm_d = StL2Chr;
        StL2Chr:  if (sub_q == 8'd15) fsm_d = StL1Addr; else sub_d = sub_q + 8'd1;
        default:  fsm_d = StPwrup;
      endcase

      if (fsm_d == StL1Addr) snap_d = state;

      // Outputs for the step about to start.
      strobe_d = 1'b1;
      rs_d     = 1'b0;
      unique case (fsm_d)
        StPwrup:  strobe_d = 1'b0;
        StFunc:   data_d = CmdFunc;
        StDisp:   data_d = CmdDisp;
        StEntry:  data_d = CmdEntry;
        StClear: begin
          data_d   = CmdClear;
          strobe_d = (sub_d == 8'd0);
        end
        StL1Addr: data_d = CmdL1Addr;
        StL2Addr: data_d = CmdL2Addr;
        StL1Chr, StL2Chr: begin
          rs_d   = 1'b1;
          data_d = chr;
        end
        default:  strobe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm_q    <= StPwrup;
      cnt_q    <= '0;
      sub_q    <= '0;
      snap_q   <= '0;
      rs_q     <= 1'b0;
      data_q   <= 8'h00;
      strobe_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      cnt_q    <= cnt_d;
      sub_q    <= sub_d;
      snap_q   <= snap_d;
      rs_q     <= rs_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
    end
  end

  assign lcd_en   = strobe_q && (32'(cnt_q) >= EN_SETUP) && (32'(cnt_q) < EN_SETUP + EN_WIDTH);
  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;
  assign lcd_rw   = 1'b0;

endmodule

// File: tb/tb_textlcd_2.sv
// Bench for textlcd_2: step-by-step comparison of LCD pins against a string-level display model.
module tb_textlcd_2;

  localparam int unsigned Tick = 50;
  localparam int unsigned Pwr  = 3;
  localparam int unsigned Clr  = 2;
  localparam int unsigned EnS  = 2;
  localparam int unsigned EnW  = 12;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] state_drv = 32'd0;
  logic        lcd_rs, lcd_rw, lcd_en;
  logic [7:0]  lcd_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] cur_snap = 32'd0;

  textlcd_2 #(
    .TICK_CYCLES   (Tick),
    .POWERUP_TICKS (Pwr),
    .CLEAR_TICKS   (Clr),
    .EN_SETUP      (EnS),
    .EN_WIDTH      (EnW)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .state    (state_drv),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en),
    .lcd_data (lcd_data)
  );

  always #5 clk = ~clk;

  // Observes one whole step starting at its count-0 cycle; leaves time at the next step's start.
  task automatic run_step(output logic [Tick-1:0] en_tr, output logic rs0, output logic [7:0] d0,
                          output logic stable, output logic rw_seen);
    en_tr   = '0;
    rs0     = lcd_rs;
    d0      = lcd_data;
    stable  = 1'b1;
    rw_seen = 1'b0;
    for (int i = 0; i < Tick; i++) begin
      en_tr[i] = lcd_en;
      if (lcd_rs !== rs0 || lcd_data !== d0) stable = 1'b0;
      if (lcd_rw !== 1'b0) rw_seen = 1'b1;
      @(negedge clk);
      #1;
    end
  endtask

  function automatic logic [Tick-1:0] en_expect(input bit strobe);
    logic [Tick-1:0] v;
    for (int i = 0; i < Tick; i++) v[i] = strobe && (i >= EnS) && (i < EnS + EnW);
    return v;
  endfunction

  function automatic string line_text(input logic [31:0] s, input bit second);
    string hex;
    string r;
    string name;
    hex = "0123456789ABCDEF";
    if (!second) begin
      name = (s == 0) ? "IDLE" : (s == 1) ? "RUN " : (s == 2) ? "STOP" : (s == 5) ? "SET " : "????";
      r = {"MODE ", name, "       "};
    end else begin
      r = "ST=0x";
      for (int i = 7; i >= 0; i--) begin
        int n;
        n = int'(s[4*i +: 4]);
        r = {r, hex.substr(n, n)};
      end
      r = {r, "   "};
    end
    return r;
  endfunction

  task automatic test_reset();
    #1 resetn = 1'b0;
    #2;
    checks++;
    if ({lcd_en, lcd_rs, lcd_rw, lcd_data} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: en/rs/rw/data=%b%b%b/%h, want 000/00", lcd_en, lcd_rs, lcd_rw,
               lcd_data);
    end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    repeat (Pwr * Tick + 5) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (lcd_en !== 1'b1 || lcd_data !== 8'h38) begin
      errors++;
      $display("FAIL pre_reset_strobe: en=%b data=%h, want en=1 data=38", lcd_en, lcd_data);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({lcd_en, lcd_rs, lcd_data} !== 10'd0) begin
      errors++;
      $display("FAIL async_reset: en/rs/data=%b%b/%h, want 00/00", lcd_en, lcd_rs, lcd_data);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({lcd_en, lcd_rs, lcd_rw, lcd_data} !== 11'd0) begin
      errors++;
      $display("FAIL reset_hold: en/rs/rw/data=%b%b%b/%h, want 000/00", lcd_en, lcd_rs, lcd_rw,
               lcd_data);
    end
  endtask

  task automatic test_init();
    logic [Tick-1:0] tr;
    logic rs;
    logic [7:0] d;
    logic stable, rw;
    logic [7:0] cmds [6];
    logic       strb [6];
    cmds = '{8'h38, 8'h0C, 8'h06, 8'h01, 8'h01, 8'h80};
    strb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    state_drv = 32'd0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    for (int s = 0; s < int'(Pwr); s++) begin
      run_step(tr, rs, d, stable, rw);
      checks++;
      if (tr !== '0 || rw) begin
        errors++;
        $display("FAIL pwrup_step%0d: en_trace=%h rw_seen=%b, want en_trace=0 rw_seen=0", s, tr, rw);
      end
    end
    for (int s = 0; s < 6; s++) begin
      run_step(tr, rs, d, stable, rw);
      checks++;
      if (tr !== en_expect(strb[s])) begin
        errors++;
        $display("FAIL init_en_step%0d: en_trace=%h, want %h", s, tr, en_expect(strb[s]));
      end
      checks++;
      if (rs !== 1'b0 || d !== cmds[s] || !stable || rw) begin
        errors++;
        $display("FAIL init_cmd_step%0d: rs=%b data=%h stable=%b rw_seen=%b, want rs=0 data=%h stable=1 rw_seen=0",
                 s, rs, d, stable, rw, cmds[s]);
      end
    end
    cur_snap = 32'd0;
  endtask

  // Checks one refresh frame (16 line-1 chars, C0, 16 line-2 chars, then the next 80);
  // optionally changes the state input at the start of step change_step (0..32).
  task automatic test_frame(input logic [31:0] new_state, input int change_step, input string tag);
    string l1, l2;
    logic [Tick-1:0] tr;
    logic rs, stable, rw, ers;
    logic [7:0] d, ed;
    l1 = line_text(cur_snap, 1'b0);
    l2 = line_text(cur_snap, 1'b1);
    for (int s = 0; s < 34; s++) begin
      if (s == change_step) state_drv = new_state;
      if (s < 16) begin
        ers = 1'b1;
        ed  = l1[s];
      end else if (s == 16) begin
        ers = 1'b0;
        ed  = 8'hC0;
      end else if (s < 33) begin
        ers = 1'b1;
        ed  = l2[s-17];
      end else begin
        ers = 1'b0;
        ed  = 8'h80;
      end
      run_step(tr, rs, d, stable, rw);
      checks++;
      if (tr !== en_expect(1'b1)) begin
        errors++;
        $display("FAIL %s_en_step%0d: en_trace=%h, want %h", tag, s, tr, en_expect(1'b1));
      end
      checks++;
      if (rs !== ers || d !== ed) begin
        errors++;
        $display("FAIL %s_byte_step%0d: rs=%b data=%h, want rs=%b data=%h", tag, s, rs, d, ers, ed);
      end
      checks++;
      if (!stable || rw) begin
        errors++;
        $display("FAIL %s_hold_step%0d: stable=%b rw_seen=%b, want stable=1 rw_seen=0", tag, s,
                 stable, rw);
      end
    end
    cur_snap = state_drv;
  endtask

  task automatic test_random_frames();
    logic [31:0] v;
    for (int k = 0; k < 4; k++) begin
      case ($urandom_range(0, 5))
        0:       v = 32'd0;
        1:       v = 32'd1;
        2:       v = 32'd2;
        3:       v = 32'd5;
        4:       v = 32'h100;
        default: v = $urandom;
      endcase
      test_frame(v, int'($urandom_range(0, 32)), "random");
    end
    test_frame(32'd0, -1, "final");
  endtask

  initial begin
    test_reset();
    test_init();
    test_frame(32'd0, -1, "idle");
    test_frame(32'd5, 8, "midchange");
    test_frame(32'd1, 20, "set");
    test_frame(32'd2, 5, "run");
    test_frame(32'hDEADBEEF, 30, "stop");
    test_frame(32'h100, 2, "deadbeef");
    test_frame(32'd0, 0, "h100");
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
